// File: rtl/alarm_clock_ctrl.sv
// Alarm clock timekeeping and alarm sequencer: tick prescaler, HH:MM:SS time, HH:MM alarm,
// button-driven set modes and the ring/snooze state machine. All outputs come from flops.
module alarm_clock_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    input  logic       alarm_en,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [2:0] mode,
    output logic       sec_pulse,
    output logic       ringing,
    output logic [1:0] alarm_state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);

    localparam logic [PW-1:0] PRE_MAX     = PW'(TICKS_PER_SEC - 1);
    localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SEC);
    localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60);

    typedef enum logic [2:0] {
        M_RUN      = 3'd0,
        M_SET_HR   = 3'd1,
        M_SET_MIN  = 3'd2,
        M_SET_AHR  = 3'd3,
        M_SET_AMIN = 3'd4
    } mode_t;

    // alarm_state debug encoding: 0 IDLE, 1 RING, 2 SNOOZE
    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } alarm_t;

    mode_t           mode_q, mode_d;
    alarm_t          a_q, a_d;
    logic [PW-1:0]   presc;
    logic [RW-1:0]   ring_cnt, ring_d;
    logic [SW-1:0]   snooze_cnt, snooze_d;

    logic time_run;
    logic sec_tick;
    logic clear_sec;
    logic inc_en;
    logic alarm_hit;

    // Time is frozen only while the clock's own hour/minute is being edited.
    assign time_run  = (mode_q == M_RUN) || (mode_q == M_SET_AHR) || (mode_q == M_SET_AMIN);
    assign sec_tick  = time_run && tick && (presc == PRE_MAX);
    assign clear_sec = mode_btn && (mode_q == M_SET_MIN);
    assign inc_en    = inc_btn && !mode_btn;
    assign alarm_hit = sec_pulse && (seconds == 6'd0) &&
                       (hours == alarm_hours) && (minutes == alarm_minutes);

    assign mode        = mode_q;
    assign alarm_state = a_q;

    always_comb begin
        mode_d = mode_q;
        if (mode_btn) begin
            case (mode_q)
                M_RUN:      mode_d = M_SET_HR;
                M_SET_HR:   mode_d = M_SET_MIN;
                M_SET_MIN:  mode_d = M_SET_AHR;
                M_SET_AHR:  mode_d = M_SET_AMIN;
                default:    mode_d = M_RUN;
            endcase
        end
    end

    always_comb begin
        a_d      = a_q;
        ring_d   = ring_cnt;
        snooze_d = snooze_cnt;
        if (!alarm_en) begin
            a_d = A_IDLE;
        end else begin
            case (a_q)
                A_IDLE: begin
                    if (alarm_hit) begin
                        a_d    = A_RING;
                        ring_d = RING_LOAD;
                    end
                end
                A_RING: begin
                    if (stop_btn) begin
                        a_d = A_IDLE;
                    end else if (snooze_btn) begin
                        a_d      = A_SNOOZE;
                        snooze_d = SNOOZE_LOAD;
                    end else if (sec_pulse) begin
                        ring_d = ring_cnt - 1'b1;
                        if (ring_cnt == RW'(1)) a_d = A_IDLE;
                    end
                end
                A_SNOOZE: begin
                    if (stop_btn) begin
                        a_d = A_IDLE;
                    end else if (sec_pulse) begin
                        if (snooze_cnt == SW'(1)) begin
                            a_d    = A_RING;
                            ring_d = RING_LOAD;
                        end else begin
                            snooze_d = snooze_cnt - 1'b1;
                        end
                    end
                end
                default: a_d = A_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= M_RUN;
            a_q        <= A_IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            ringing    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            a_q        <= a_d;
            ring_cnt   <= ring_d;
            snooze_cnt <= snooze_d;
            ringing    <= (a_d == A_RING);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc         <= '0;
            seconds       <= '0;
            minutes       <= '0;
            hours         <= '0;
            alarm_hours   <= 5'd6;
            alarm_minutes <= '0;
            sec_pulse     <= 1'b0;
        end else begin
            sec_pulse <= sec_tick;
            if (clear_sec) begin
                presc   <= '0;
                seconds <= '0;
            end else if (time_run && tick) begin
                if (presc == PRE_MAX) begin
                    presc <= '0;
                    if (seconds == 6'd59) begin
                        seconds <= '0;
                        if (minutes == 6'd59) begin
                            minutes <= '0;
                            hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                        end else begin
                            minutes <= minutes + 6'd1;
                        end
                    end else begin
                        seconds <= seconds + 6'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            // Edited fields never collide with carries: hours/minutes edits happen only while frozen.
            if (inc_en) begin
                case (mode_q)
                    M_SET_HR:   hours         <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                    M_SET_MIN:  minutes       <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                    M_SET_AHR:  alarm_hours   <= (alarm_hours == 5'd23) ? 5'd0 : alarm_hours + 5'd1;
                    M_SET_AMIN: alarm_minutes <= (alarm_minutes == 6'd59) ? 6'd0 : alarm_minutes + 6'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed scenarios plus random stimulus, every cycle checked
// against a seconds-of-day reference model through an expected-value queue.
module tb_alarm_clock_ctrl;

    localparam int TPS  = 4;
    localparam int RSEC = 3;
    localparam int SMIN = 1;
    localparam int W    = 35;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [2:0] mode;
    logic       sec_pulse;
    logic       ringing;
    logic [1:0] alarm_state;

    always #5 clk = ~clk;

    alarm_clock_ctrl #(
        .TICKS_PER_SEC(TPS),
        .RING_SEC(RSEC),
        .SNOOZE_MIN(SMIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .mode_btn(mode_btn),
        .inc_btn(inc_btn),
        .snooze_btn(snooze_btn),
        .stop_btn(stop_btn),
        .alarm_en(alarm_en),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .mode(mode),
        .sec_pulse(sec_pulse),
        .ringing(ringing),
        .alarm_state(alarm_state)
    );

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds of day, alarm as minute of day.
    int m_t, m_pre, m_mode, m_ah, m_am, m_pulse, m_st, m_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int old_t, old_pulse, new_pulse;
        bit running;
        if (!reset) begin
            m_t = 0; m_pre = 0; m_mode = 0; m_ah = 6; m_am = 0;
            m_pulse = 0; m_st = 0; m_left = 0;
        end else begin
            old_t = m_t;
            old_pulse = m_pulse;
            if (!alarm_en) begin
                m_st = 0;
            end else if (m_st == 0) begin
                if (old_pulse == 1 && old_t % 60 == 0 && old_t / 60 == m_ah * 60 + m_am) begin
                    m_st = 1; m_left = RSEC;
                end
            end else if (m_st == 1) begin
                if (stop_btn) m_st = 0;
                else if (snooze_btn) begin m_st = 2; m_left = SMIN * 60; end
                else if (old_pulse == 1) begin
                    if (m_left == 1) m_st = 0;
                    m_left--;
                end
            end else begin
                if (stop_btn) m_st = 0;
                else if (old_pulse == 1) begin
                    if (m_left == 1) begin m_st = 1; m_left = RSEC; end
                    else m_left--;
                end
            end
            new_pulse = 0;
            running = (m_mode == 0) || (m_mode >= 3);
            if (running && tick) begin
                if (m_pre == TPS - 1) begin
                    m_pre = 0;
                    m_t = (m_t + 1) % 86400;
                    new_pulse = 1;
                end else begin
                    m_pre++;
                end
            end
            if (mode_btn) begin
                if (m_mode == 2) begin m_t = m_t - m_t % 60; m_pre = 0; end
                m_mode = (m_mode + 1) % 5;
            end else if (inc_btn) begin
                case (m_mode)
                    1: m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
                    2: m_t = (m_t / 3600) * 3600 + ((m_t / 60 % 60 + 1) % 60) * 60 + m_t % 60;
                    3: m_ah = (m_ah + 1) % 24;
                    4: m_am = (m_am + 1) % 60;
                    default: ;
                endcase
            end
            m_pulse = new_pulse;
        end
        exp_q.push_back({2'(m_st), (m_st == 1), 1'(m_pulse), 3'(m_mode), 5'(m_ah), 6'(m_am),
                         5'(m_t / 3600), 6'(m_t / 60 % 60), 6'(m_t % 60)});
    endtask

    task automatic compare_outputs();
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq("seconds", seconds, e[5:0]);
        check_eq("minutes", minutes, e[11:6]);
        check_eq("hours", hours, e[16:12]);
        check_eq("alarm_minutes", alarm_minutes, e[22:17]);
        check_eq("alarm_hours", alarm_hours, e[27:23]);
        check_eq("mode", mode, e[30:28]);
        check_eq("sec_pulse", sec_pulse, e[31]);
        check_eq("ringing", ringing, e[32]);
        check_eq("alarm_state", alarm_state, e[34:33]);
    endtask

    task automatic cyc(input bit t, input bit mb, input bit ib, input bit sb, input bit pb);
        tick = t; mode_btn = mb; inc_btn = ib; snooze_btn = sb; stop_btn = pb;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
    endtask

    // From RUN: walk to SET_AHR (clears seconds on the way), edit alarm, return to RUN.
    task automatic set_alarm(input int h, input int m);
        press_mode(3);
        press_inc((h - m_ah + 24) % 24);
        press_mode(1);
        press_inc((m - m_am + 60) % 60);
        press_mode(1);
    endtask

    task automatic run_until_ring(input string tag, input int max_cycles);
        int k = 0;
        while (ringing !== 1'b1 && k < max_cycles) begin
            cyc(1, 0, 0, 0, 0);
            k++;
        end
        check_eq(tag, ringing, 1);
    endtask

    initial begin
        int pulses, k;
        bit rang;

        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check_eq("rst_hours", hours, 0);
        check_eq("rst_alarm_hours", alarm_hours, 6);
        check_eq("rst_mode", mode, 0);
        check_eq("rst_ringing", ringing, 0);
        reset = 1'b1;

        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (sec_pulse) pulses++;
            cyc(0, 0, 0, 0, 0);
            if (sec_pulse) pulses++;
        end
        check_eq("prescale_pulses", pulses, 2);
        check_eq("prescale_seconds", seconds, 2);

        press_mode(1); press_inc(23); press_mode(1); press_inc(59); press_mode(3);
        ticks(59 * TPS);
        check_eq("preload_hms", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});
        ticks(TPS);
        check_eq("midnight_hms", {hours, minutes, seconds}, 0);
        check_eq("midnight_pulse", sec_pulse, 1);

        ticks(TPS);
        press_mode(1); press_inc(25);
        check_eq("hour_wrap", hours, 1);
        ticks(8);
        check_eq("frozen_seconds", seconds, 1);
        check_eq("frozen_pulse", sec_pulse, 0);
        press_mode(2);
        check_eq("leave_setmin_seconds", seconds, 0);
        check_eq("leave_setmin_mode", mode, 3);
        press_mode(2);

        press_mode(1); press_inc(23);
        cyc(0, 1, 1, 0, 0);
        check_eq("mode_inc_mode", mode, 2);
        check_eq("mode_inc_fields", {hours, minutes}, 0);
        press_mode(3);

        set_alarm(0, 1);
        alarm_en = 1'b1;
        ticks(59 * TPS);
        check_eq("pre_alarm_seconds", seconds, 59);
        ticks(TPS);
        check_eq("trigger_pulse", sec_pulse, 1);
        check_eq("trigger_ringing", ringing, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("ring_rise", ringing, 1);
        pulses = 0; k = 0;
        while (ringing === 1'b1 && k < 200) begin
            cyc(1, 0, 0, 0, 0);
            if (ringing === 1'b1 && sec_pulse) pulses++;
            k++;
        end
        check_eq("ring_timeout", ringing, 0);
        check_eq("ring_length", pulses, RSEC);

        set_alarm(0, 2);
        run_until_ring("ring2", 400);
        cyc(0, 0, 0, 1, 0);
        check_eq("snooze_ringing", ringing, 0);
        check_eq("snooze_state", alarm_state, 2);
        pulses = 0; k = 0;
        while (ringing !== 1'b1 && k < 600) begin
            cyc(1, 0, 0, 0, 0);
            if (ringing !== 1'b1 && sec_pulse) pulses++;
            k++;
        end
        check_eq("snooze_rering", ringing, 1);
        check_eq("snooze_length", pulses, SMIN * 60);
        cyc(0, 0, 0, 1, 1);
        check_eq("stop_snooze_ringing", ringing, 0);
        check_eq("stop_snooze_state", alarm_state, 0);

        set_alarm(0, 4);
        run_until_ring("ring3", 400);
        cyc(0, 0, 0, 1, 0);
        ticks(8);
        alarm_en = 1'b0;
        cyc(0, 0, 0, 0, 0);
        check_eq("en_drop_state", alarm_state, 0);
        rang = 0;
        for (int i = 0; i < 70 * TPS; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (ringing === 1'b1) rang = 1;
        end
        check_eq("no_rering", rang, 0);

        alarm_en = 1'b1;
        set_alarm(0, 6);
        run_until_ring("ring4", 400);
        press_mode(4);
        check_eq("pre_reset_mode", mode, 4);
        reset = 1'b0;
        cyc(1, 1, 1, 1, 1);
        check_eq("mid_reset_time", {hours, minutes, seconds}, 0);
        check_eq("mid_reset_alarm", {alarm_hours, alarm_minutes}, {5'd6, 6'd0});
        check_eq("mid_reset_mode", mode, 0);
        check_eq("mid_reset_ringing", ringing, 0);
        check_eq("mid_reset_pulse", sec_pulse, 0);
        reset = 1'b1;

        set_alarm(0, 1);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
